alu_flag_writeback: RTL

- Downstream stage of the 8-bit ALU. Consumes each ALU result with its carry/zero/negative/overflow flags, buffers it in a 2-entry queue, and commits it to a small register file and a 4-bit status register.
- Register-file read ports supply the A/B operands for the next ALU operation, which closes the accumulator loop.

---
 rtl/alu_flag_writeback.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback: queues ALU result bundles (2 deep) and commits them to a register file and a {C,Z,N,V} status register.
// Latency: a bundle pushed at edge N into an empty queue commits at edge N+1 (hold low); commit_pulse is high the cycle after.
// Backpressure: in_ready = !full; hold stalls commits only. Optional macro STICKY_OVF_EN makes V sticky across ADD/SUB commits.

module alu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module alu_flag_writeback #(
  parameter int REG_COUNT = 4,
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic [2:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wr_en,
  input  logic              in_flags_en,
  input  logic              hold,
  input  logic              flag_clr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [7:0]        rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [7:0]        rd_data_b,
  output logic [3:0]        flags_q,
  output logic              commit_pulse,
  output logic [CNT_W-1:0]  commit_count
);
  typedef struct packed {
    logic [7:0]        result;
    logic              c;
    logic              z;
    logic              n;
    logic              v;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] dest;
    logic              wr_en;
    logic              flags_en;
  } entry_t;

  entry_t     push_dat;
  entry_t     head;
  logic       q_empty;
  logic       q_full;
  logic       push;
  logic       pop;
  logic [3:0] flags_nxt;
  logic [7:0] regs [REG_COUNT];

  assign push_dat = '{result: in_result, c: in_carry, z: in_zero, n: in_negative,
                      v: in_overflow, opcode: in_opcode, dest: in_dest,
                      wr_en: in_wr_en, flags_en: in_flags_en};

  // rst_n gates in_ready so the reset cycle never advertises space
  assign in_ready = rst_n && !q_full;
  assign push     = in_valid && in_ready;
  assign pop      = rst_n && !q_empty && !hold;

  alu_wb_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (2)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  // flag_clr applies first so a same-edge commit overrides it
  always_comb begin
    flags_nxt = flag_clr ? 4'b0000 : flags_q;
    if (pop && head.flags_en) begin
      flags_nxt[2] = head.z;
      flags_nxt[1] = head.n;
      if (head.opcode[2:1] == 2'b00) begin
        flags_nxt[3] = head.c;
`ifdef STICKY_OVF_EN
        flags_nxt[0] = flags_nxt[0] | head.v;
`else
        flags_nxt[0] = head.v;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= 8'h00;
      end
      flags_q      <= 4'b0000;
      commit_pulse <= 1'b0;
      commit_count <= '0;
    end else begin
      if (pop && head.wr_en) begin
        regs[head.dest] <= head.result;
      end
      flags_q      <= flags_nxt;
      commit_pulse <= pop;
      if (pop) begin
        commit_count <= commit_count + CNT_W'(1);
      end
    end
  end
endmodule
